// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types used by the ID-stage scoreboard.
package cpu_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned REG_W = 5;

    // Bit positions inside the ID-stage source-use control.
    localparam int unsigned USE_RS   = 0;
    localparam int unsigned USE_RT   = 1;
    localparam int unsigned USE_RTRS = 2;

    typedef logic [REG_W-1:0] reg_num_t;

endpackage

// File: rtl/sb_cnt.sv
// Pending-writer counter for one GPR: up on issue, down on retire, cleared on flush.
module sb_cnt #(
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic eff_zero,
    output logic full_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;

    // Issue and retire together cancel; a retire against an empty count is dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // With bypass, the last pending write retiring this cycle already counts as free.
    always_comb begin
        eff_zero = (cnt == '0) || ((WB_BYPASS != 0) && dec && cnt == CNT_W'(1));
        full_c   = (cnt == CNT_MAX);
    end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register-dependency scoreboard: per-GPR pending-writer counts gate issue into EXE.
module id_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_use,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_wen,
    input  logic [4:0]  id_wr,
    input  logic        exe_allowin,
    input  logic        wb_valid,
    input  logic        wb_wen,
    input  logic [4:0]  wb_wr,
    input  logic        flush,
    output logic        id_issue,
    output logic        id_stall,
    output logic [31:0] stall_cnt
);

    import cpu_pkg::*;

    logic [NREG-1:0] eff_zero;
    logic [NREG-1:0] full;
    logic            rs_busy;
    logic            rt_busy;
    logic            wr_full;
    logic            hazard;

    // $0 is never written, so it is always free and never saturates.
    assign eff_zero[0] = 1'b1;
    assign full[0]     = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc;
        logic dec;

        always_comb begin
            inc = id_issue && id_wen && (id_wr == REG_W'(r));
            dec = wb_valid && wb_wen && (wb_wr == REG_W'(r));
        end

        sb_cnt #(
            .CNT_W     (CNT_W),
            .WB_BYPASS (WB_BYPASS)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc),
            .dec      (dec),
            .clr      (flush),
            .eff_zero (eff_zero[r]),
            .full_c   (full[r])
        );
    end

    // Source dependencies plus destination-counter saturation decide the hazard.
    always_comb begin
        rs_busy  = (id_rs != '0) && !eff_zero[id_rs];
        rt_busy  = (id_rt != '0) && !eff_zero[id_rt];
        wr_full  = id_wen && (id_wr != '0) && full[id_wr];
        hazard   = ((id_use[USE_RS] || id_use[USE_RTRS]) && rs_busy)
                 || ((id_use[USE_RT] || id_use[USE_RTRS]) && rt_busy)
                 || wr_full;
        id_stall = id_valid && hazard && !flush;
        id_issue = id_valid && exe_allowin && !hazard && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: bypass and non-bypass instances share one stimulus stream.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_use;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_wen;
    logic [4:0]  id_wr;
    logic        exe_allowin;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_wr;
    logic        flush;
    logic        issue1, stall1, issue0, stall0;
    logic [31:0] scnt1, scnt0;

    always #5 clk = ~clk;

    id_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_use(id_use), .id_rs(id_rs),
        .id_rt(id_rt), .id_wen(id_wen), .id_wr(id_wr), .exe_allowin(exe_allowin),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wr(wb_wr), .flush(flush),
        .id_issue(issue1), .id_stall(stall1), .stall_cnt(scnt1)
    );

    id_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(0)) dut_nobp (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_use(id_use), .id_rs(id_rs),
        .id_rt(id_rt), .id_wen(id_wen), .id_wr(id_wr), .exe_allowin(exe_allowin),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wr(wb_wr), .flush(flush),
        .id_issue(issue0), .id_stall(stall0), .stall_cnt(scnt0)
    );

    typedef struct {
        string tag;
        logic  i1;
        logic  s1;
        logic  i0;
        logic  s0;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   sc1      = 0;
    int   sc0      = 0;
    int   mc[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_valid = 1'b0; id_use = 3'b000; id_rs = 5'd0; id_rt = 5'd0;
        id_wen = 1'b0; id_wr = 5'd0; exe_allowin = 1'b1;
        wb_valid = 1'b0; wb_wen = 1'b0; wb_wr = 5'd0; flush = 1'b0;
    endtask

    // One cycle: queue the expectation, compare mid-cycle, advance the reference counts.
    task automatic step(input string tag, input logic ei1, input logic es1,
                        input logic ei0, input logic es0);
        exp_t e;
        e.tag = tag; e.i1 = ei1; e.s1 = es1; e.i0 = ei0; e.s0 = es0;
        q.push_back(e);
        #2;
        e = q.pop_front();
        chk({e.tag, ".issue_bp1"}, 32'(issue1), 32'(e.i1));
        chk({e.tag, ".stall_bp1"}, 32'(stall1), 32'(e.s1));
        chk({e.tag, ".issue_bp0"}, 32'(issue0), 32'(e.i0));
        chk({e.tag, ".stall_bp0"}, 32'(stall0), 32'(e.s0));
        if (wb_valid && wb_wen && wb_wr != 5'd0)
            assert (mc[wb_wr] > 0) else $error("protocol: retire of idle register %0d", wb_wr);
        @(posedge clk);
        if (rst || flush) begin
            for (int r = 0; r < 32; r++) mc[r] = 0;
        end else begin
            if (ei1 && id_wen && id_wr != 5'd0) mc[id_wr]++;
            if (wb_valid && wb_wen && wb_wr != 5'd0) mc[wb_wr]--;
        end
        if (rst) begin
            sc1 = 0;
            sc0 = 0;
        end else begin
            sc1 += int'(es1);
            sc0 += int'(es0);
        end
        #1;
        idle();
    endtask

    task automatic chk_sc(input string tag);
        chk({tag, ".stall_cnt_bp1"}, scnt1, 32'(sc1));
        chk({tag, ".stall_cnt_bp0"}, scnt0, 32'(sc0));
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mc[r] = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall_cnt_bp1", scnt1, 32'd0);
        chk("reset.stall_cnt_bp0", scnt0, 32'd0);

        rst = 1'b1; id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd3;
        step("reset_comb", 1, 0, 1, 0);

        // Writer to $3, reader waits for its retire.
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd3;
        step("A_writer", 1, 0, 1, 0);
        repeat (3) begin
            id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd3;
            step("A_wait", 0, 1, 0, 1);
        end
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd3;
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd3;
        step("A_retire", 1, 0, 0, 1);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd3;
        step("A_after", 1, 0, 1, 0);
        chk_sc("A");
        chk("A.stall_cnt_const", scnt1, 32'd3);

        // Use-control masking with $5 busy and $6 free.
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd5;
        step("B_writer", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b010; id_rs = 5'd5; id_rt = 5'd6;
        step("B_use_rt", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd5; id_rt = 5'd6;
        step("B_use_rtrs", 0, 1, 0, 1);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd5; id_rt = 5'd6;
        step("B_use_rs", 0, 1, 0, 1);
        id_valid = 1'b1; id_use = 3'b010; id_rs = 5'd5; id_rt = 5'd6; exe_allowin = 1'b0;
        step("B_noallow", 0, 0, 0, 0);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd5; exe_allowin = 1'b0;
        step("B_noallow_haz", 0, 1, 0, 1);
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd5;
        step("B_retire", 0, 0, 0, 0);
        chk_sc("B");

        // $0 is never tracked: repeated writes neither saturate nor block readers.
        repeat (4) begin
            id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd0;
            step("C_write0", 1, 0, 1, 0);
        end
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd0; id_rt = 5'd0;
        step("C_read0", 1, 0, 1, 0);

        // Two writers to $7, reader needs both retires; issue+retire together holds count.
        repeat (2) begin
            id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd7;
            step("D_writer", 1, 0, 1, 0);
        end
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        step("D_wait2", 0, 1, 0, 1);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd7;
        step("D_retire1", 0, 1, 0, 1);
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd7;
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd7;
        step("D_iss_ret", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        step("D_wait1", 0, 1, 0, 1);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd7;
        step("D_retire2", 1, 0, 0, 1);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        step("D_after", 1, 0, 1, 0);
        chk_sc("D");
        repeat (3) begin
            id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd7;
            step("D_fill", 1, 0, 1, 0);
        end
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd7;
        step("D_full", 0, 1, 0, 1);

        // Flush with cnt[4]=2, cnt[9]=1, cnt[7]=3 and a retire of $4 in the same cycle.
        repeat (2) begin
            id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd4;
            step("E_w4", 1, 0, 1, 0);
        end
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd9;
        step("E_w9", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd4; id_rt = 5'd9; flush = 1'b1;
        wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd4;
        step("E_flush", 0, 0, 0, 0);
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd4; id_rt = 5'd9; flush = 1'b1;
        step("E_flush_free", 0, 0, 0, 0);
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd4; id_rt = 5'd9;
        id_wen = 1'b1; id_wr = 5'd7;
        step("E_after", 1, 0, 1, 0);
        chk_sc("E");

        // Same setup, cleared by reset instead of flush.
        repeat (2) begin
            id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd4;
            step("F_w4", 1, 0, 1, 0);
        end
        id_valid = 1'b1; id_wen = 1'b1; id_wr = 5'd9;
        step("F_w9", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd9;
        step("F_wait", 0, 1, 0, 1);
        rst = 1'b1; wb_valid = 1'b1; wb_wen = 1'b1; wb_wr = 5'd4;
        step("F_rst", 0, 0, 0, 0);
        chk_sc("F");
        chk("F.stall_cnt_zero", scnt0, 32'd0);
        id_valid = 1'b1; id_use = 3'b100; id_rs = 5'd4; id_rt = 5'd9;
        step("F_read49", 1, 0, 1, 0);
        id_valid = 1'b1; id_use = 3'b001; id_rs = 5'd7;
        step("F_read7", 1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
